// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage: one shift-add or restoring
// subtract step per cycle, producing {Hi,Lo} with a stall request while it works.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               StartIn,
  input  logic [1:0]         OpIn,
  input  logic [WIDTH-1:0]   ReadData1In,
  input  logic [WIDTH-1:0]   ReadData2In,
  input  logic               FlushIn,
  output logic               BusyOut,
  output logic               DoneOut,
  output logic [2*WIDTH-1:0] HiLoOut,
  output logic               DivZeroOut
);

  // state | meaning
  // Idle  | waiting for a mult/div instruction in EX
  // Run   | one iteration per cycle, WIDTH iterations total
  // Done  | result presented for one cycle while the pipeline advances
  typedef enum logic [1:0] {Idle, Run, Done} stateT;

  localparam int CW = $clog2(WIDTH);

  stateT              state, nextState;
  logic [CW-1:0]      count;
  logic [1:0]         opReg;
  logic [WIDTH:0]     hiAcc;
  logic [WIDTH-1:0]   loAcc;
  logic [WIDTH-1:0]   operand;
  logic               negResult, negRem, divZeroPending;
  logic [2*WIDTH-1:0] hiLoReg;
  logic               divZeroReg;

  logic               signedIn, divisorZero, startOk;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] prodMag, prodFix, result;
  logic [WIDTH-1:0]   quotFix, remFix;

  assign signedIn    = ~OpIn[0];
  assign divisorZero = OpIn[1] & (ReadData2In == '0);
  assign startOk     = StartIn & ~FlushIn;
  assign absA        = (signedIn && ReadData1In[WIDTH-1]) ? -ReadData1In : ReadData1In;
  assign absB        = (signedIn && ReadData2In[WIDTH-1]) ? -ReadData2In : ReadData2In;

  // Multiply: multiplier sits in loAcc and shifts out LSB-first into the accumulator.
  assign mulSum   = loAcc[0] ? (hiAcc + {1'b0, operand}) : hiAcc;
  // Divide: partial remainder is one bit wider so the borrow shows up in the MSB.
  assign divShift = {hiAcc[WIDTH-1:0], loAcc[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand};

  assign prodMag = {hiAcc[WIDTH-1:0], loAcc};
  assign prodFix = negResult ? -prodMag : prodMag;
  assign quotFix = negResult ? -loAcc : loAcc;
  assign remFix  = negRem ? -hiAcc[WIDTH-1:0] : hiAcc[WIDTH-1:0];
  assign result  = divZeroPending ? {loAcc, {WIDTH{1'b1}}} :
                   opReg[1]       ? {remFix, quotFix} : prodFix;

  always_ff @(posedge Clk) begin
    if (!Reset) state <= Idle;
    else        state <= nextState;
  end

  always_comb begin
    nextState  = state;
    BusyOut    = 1'b0;
    DoneOut    = 1'b0;
    HiLoOut    = hiLoReg;
    DivZeroOut = divZeroReg;
    case (state)
      Idle: begin
        if (startOk) begin
          BusyOut   = 1'b1;
          nextState = divisorZero ? Done : Run;
        end
      end
      Run: begin
        BusyOut = 1'b1;
        if (FlushIn)                         nextState = Idle;
        else if (count == CW'(WIDTH - 1))    nextState = Done;
      end
      Done: begin
        nextState = Idle;
        if (!FlushIn) begin
          DoneOut    = 1'b1;
          HiLoOut    = result;
          DivZeroOut = divZeroPending;
        end
      end
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count          <= '0;
      opReg          <= '0;
      hiAcc          <= '0;
      loAcc          <= '0;
      operand        <= '0;
      negResult      <= 1'b0;
      negRem         <= 1'b0;
      divZeroPending <= 1'b0;
      hiLoReg        <= '0;
      divZeroReg     <= 1'b0;
    end else begin
      case (state)
        Idle: begin
          if (startOk) begin
            count          <= '0;
            opReg          <= OpIn;
            hiAcc          <= '0;
            // A zero divisor keeps the raw dividend so it can be returned in Hi.
            loAcc          <= divisorZero ? ReadData1In : absA;
            operand        <= absB;
            negResult      <= signedIn & (ReadData1In[WIDTH-1] ^ ReadData2In[WIDTH-1]);
            negRem         <= signedIn & ReadData1In[WIDTH-1];
            divZeroPending <= divisorZero;
          end
        end
        Run: begin
          count <= count + CW'(1);
          if (opReg[1]) begin
            if (!divDiff[WIDTH]) begin
              hiAcc <= divDiff;
              loAcc <= {loAcc[WIDTH-2:0], 1'b1};
            end else begin
              hiAcc <= divShift;
              loAcc <= {loAcc[WIDTH-2:0], 1'b0};
            end
          end else begin
            hiAcc <= {1'b0, mulSum[WIDTH:1]};
            loAcc <= {mulSum[0], loAcc[WIDTH-1:1]};
          end
        end
        Done: begin
          if (!FlushIn) begin
            hiLoReg    <= result;
            divZeroReg <= divZeroPending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected {DivZero,HiLo} pushed at issue,
// popped and compared by a monitor whenever DoneOut pulses.
module tb_ex_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        StartIn;
  logic [1:0]  OpIn;
  logic [31:0] ReadData1In, ReadData2In;
  logic        FlushIn;
  logic        BusyOut, DoneOut, DivZeroOut;
  logic [63:0] HiLoOut;

  int passCnt = 0;
  int totalCnt = 0;
  logic [64:0] expQ[$];
  logic [64:0] lastExp;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .StartIn(StartIn), .OpIn(OpIn),
    .ReadData1In(ReadData1In), .ReadData2In(ReadData2In), .FlushIn(FlushIn),
    .BusyOut(BusyOut), .DoneOut(DoneOut), .HiLoOut(HiLoOut), .DivZeroOut(DivZeroOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain signed/unsigned arithmetic; SV '/' and '%' truncate toward zero.
  function automatic logic [64:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) begin
      p = 64'(sa * sb);
      return {1'b0, p};
    end else if (op == 2'b01) begin
      p = {32'b0, a} * {32'b0, b};
      return {1'b0, p};
    end else if (b == 32'd0) begin
      return {1'b1, a, 32'hFFFFFFFF};
    end else if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end else begin
      uq = a / b;
      ur = a % b;
      return {1'b0, ur, uq};
    end
  endfunction

  always @(negedge Clk) begin
    if (Reset === 1'b1 && DoneOut === 1'b1) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_done: got DoneOut=1 HiLo=%h expected no pending op", HiLoOut);
      end else begin
        logic [64:0] e;
        e = expQ.pop_front();
        check("hilo", HiLoOut, e[63:0]);
        check("divzero", 64'(DivZeroOut), 64'(e[64]));
      end
    end
  end

  // Called just after a posedge; returns just after the posedge following DONE,
  // with StartIn still high (held through DONE like a stalled instruction).
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, busyCnt, expLat;
    lastExp = refModel(op, a, b);
    expQ.push_back(lastExp);
    expLat = (op[1] && b == 32'd0) ? 1 : 33;
    StartIn = 1'b1; OpIn = op; ReadData1In = a; ReadData2In = b;
    lat = -1; busyCnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clk);
      if (DoneOut) begin
        lat = c;
        break;
      end
      if (BusyOut) busyCnt++;
      @(posedge Clk); #1;
    end
    check("latency", 64'(lat), 64'(expLat));
    check("busy_cycles", 64'(busyCnt), 64'(expLat));
    if (lat >= 0) check("busy_in_done", 64'(BusyOut), 64'd0);
    @(posedge Clk); #1;
  endtask

  task automatic idleGap();
    StartIn = 1'b0;
    @(negedge Clk);
    check("no_retrigger", 64'(BusyOut), 64'd0);
    check("hold_hilo", HiLoOut, lastExp[63:0]);
    check("hold_divzero", 64'(DivZeroOut), 64'(lastExp[64]));
    @(posedge Clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    Reset = 1'b0; StartIn = 1'b0; OpIn = 2'b00; FlushIn = 1'b0;
    ReadData1In = '0; ReadData2In = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_hilo", HiLoOut, 64'd0);
    check("reset_done", 64'(DoneOut), 64'd0);
    check("reset_divzero", 64'(DivZeroOut), 64'd0);
    check("reset_busy", 64'(BusyOut), 64'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idleGap();
    runOp(2'b00, 32'hFFFFFFFD, 32'd7);
    runOp(2'b11, 32'd100, 32'd7);
    idleGap();
    runOp(2'b10, 32'hFFFFFFF9, 32'd2);
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF);
    idleGap();
    runOp(2'b10, 32'd5, 32'd0);
    idleGap();

    // Flush mid-multiply: no result, previous outputs retained.
    StartIn = 1'b1; OpIn = 2'b00; ReadData1In = 32'd123; ReadData2In = 32'd456;
    repeat (10) begin @(posedge Clk); #1; end
    FlushIn = 1'b1; StartIn = 1'b0;
    @(negedge Clk);
    check("flush_busy_run", 64'(BusyOut), 64'd1);
    @(posedge Clk); #1;
    FlushIn = 1'b0;
    @(negedge Clk);
    check("flush_idle_busy", 64'(BusyOut), 64'd0);
    check("flush_hold_hilo", HiLoOut, lastExp[63:0]);
    check("flush_hold_divzero", 64'(DivZeroOut), 64'(lastExp[64]));
    repeat (40) @(posedge Clk);
    #1;
    check("flush_late_hilo", HiLoOut, lastExp[63:0]);

    // Reset mid-multiply clears everything.
    StartIn = 1'b1; OpIn = 2'b00; ReadData1In = 32'h1234; ReadData2In = 32'h5678;
    repeat (10) begin @(posedge Clk); #1; end
    Reset = 1'b0; StartIn = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_hilo", HiLoOut, 64'd0);
    check("rst_done", 64'(DoneOut), 64'd0);
    check("rst_divzero", 64'(DivZeroOut), 64'd0);
    check("rst_busy", 64'(BusyOut), 64'd0);
    repeat (40) @(posedge Clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      runOp(op, a, b);
      if ($urandom_range(0, 1) == 1) idleGap();
    end
    StartIn = 1'b0;
    repeat (40) @(posedge Clk);
    #1;

    check("queue_empty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
